// File: rtl/dotprod_stream.sv
// Streaming dot-product engine: accumulates sum(a[i]*b[i]) over a runtime
// number of element pairs, in signed or unsigned mode chosen per operation.
// Two-stage datapath: product register, then accumulator with a sticky
// overflow flag. Result and overflow are published with a one-cycle done pulse.
module dotprod_stream #(
  parameter int DATA_W = 32,
  parameter int LEN_W  = 8,
  parameter int ACC_W  = 72
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [LEN_W-1:0]  len,
  input  logic              signed_mode,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_a,
  input  logic [DATA_W-1:0] in_b,
  output logic              busy,
  output logic              done,
  output logic [ACC_W-1:0]  result,
  output logic              overflow
);

  localparam int PROD_W = 2 * DATA_W;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  state_t                    state;
  logic [LEN_W-1:0]          len_q;
  logic [LEN_W-1:0]          cnt;
  logic                      sgn_q;
  logic                      accept;

  logic signed [PROD_W-1:0]  prod_p1;
  logic                      vld_p1;
  logic signed [ACC_W-1:0]   addend_p1;
  logic signed [ACC_W-1:0]   acc_p2;
  logic                      ovf_p2;

  // Full-width product; operands are sign- or zero-extended to PROD_W first,
  // so one multiply serves both modes and the low PROD_W bits are exact.
  function automatic logic signed [PROD_W-1:0] mul_ext(
    input logic [DATA_W-1:0] a,
    input logic [DATA_W-1:0] b,
    input logic              sgn
  );
    logic signed [PROD_W-1:0] ax;
    logic signed [PROD_W-1:0] bx;
    ax = $signed({{DATA_W{sgn & a[DATA_W-1]}}, a});
    bx = $signed({{DATA_W{sgn & b[DATA_W-1]}}, b});
    return ax * bx;
  endfunction

  // Widen the product to accumulator width according to the operation mode.
  function automatic logic signed [ACC_W-1:0] widen(
    input logic signed [PROD_W-1:0] p,
    input logic                     sgn
  );
    if (sgn) return ACC_W'(p);
    return $signed(ACC_W'($unsigned(p)));
  endfunction

  // Overflow of acc + x: carry out when unsigned, sign flip of like-signed
  // operands when signed.
  function automatic logic add_ovf(
    input logic signed [ACC_W-1:0] acc,
    input logic signed [ACC_W-1:0] x,
    input logic                    sgn
  );
    logic [ACC_W:0]   wide;
    logic [ACC_W-1:0] sum;
    wide = {1'b0, acc} + {1'b0, x};
    sum  = wide[ACC_W-1:0];
    if (sgn) return (acc[ACC_W-1] == x[ACC_W-1]) && (sum[ACC_W-1] != acc[ACC_W-1]);
    return wide[ACC_W];
  endfunction

  assign accept    = in_valid && in_ready;
  assign addend_p1 = widen(prod_p1, sgn_q);

  // Control FSM with registered handshake/status outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      in_ready <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      result   <= '0;
      overflow <= 1'b0;
      len_q    <= '0;
      sgn_q    <= 1'b0;
      cnt      <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            len_q <= len;
            sgn_q <= signed_mode;
            cnt   <= '0;
            busy  <= 1'b1;
            if (len != '0) begin
              state    <= RUN;
              in_ready <= 1'b1;
            end else begin
              state <= DONE;
            end
          end
        end
        RUN: begin
          if (accept) begin
            cnt <= cnt + LEN_W'(1);
            if (cnt == len_q - LEN_W'(1)) begin
              state    <= DRAIN;
              in_ready <= 1'b0;
            end
          end
        end
        DRAIN: state <= DONE;
        DONE: begin
          result   <= $unsigned(acc_p2);
          overflow <= ovf_p2;
          done     <= 1'b1;
          busy     <= 1'b0;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Stage p1: register the product of each accepted pair
  // Stage p2: accumulate qualified products and track sticky overflow
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prod_p1 <= '0;
      vld_p1  <= 1'b0;
      acc_p2  <= '0;
      ovf_p2  <= 1'b0;
    end else begin
      vld_p1 <= accept;
      if (accept) prod_p1 <= mul_ext(in_a, in_b, sgn_q);
      if (state == IDLE && start) begin
        acc_p2 <= '0;
        ovf_p2 <= 1'b0;
      end else if (vld_p1) begin
        acc_p2 <= acc_p2 + addend_p1;
        if (add_ovf(acc_p2, addend_p1, sgn_q)) ovf_p2 <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_dotprod_stream.sv
// Bench for dotprod_stream: a wide instance (32/8/72) and a narrow one
// (8/8/16) for overflow cases. Expected results are queued at stimulus time
// and compared by per-instance monitors whenever done is seen.
module tb_dotprod_stream;

  logic         clk = 1'b0;
  logic         rst;
  // wide instance
  logic         start, signed_mode, in_valid, in_ready, busy, done, overflow;
  logic [7:0]   len;
  logic [31:0]  in_a, in_b;
  logic [71:0]  result;
  // narrow instance
  logic         start_s, signed_mode_s, in_valid_s, in_ready_s, busy_s, done_s, overflow_s;
  logic [7:0]   len_s;
  logic [7:0]   in_a_s, in_b_s;
  logic [15:0]  result_s;

  typedef struct {
    logic [127:0] res;
    bit           ovf;
  } exp_t;

  exp_t         q32[$];
  exp_t         q8[$];
  int           tests = 0;
  int           fails = 0;
  int           rdy_viol = 0;
  logic [31:0]  qa[$], qb[$];

  always #5 clk = ~clk;

  dotprod_stream #(.DATA_W(32), .LEN_W(8), .ACC_W(72)) dut (
    .clk(clk), .rst(rst), .start(start), .len(len), .signed_mode(signed_mode),
    .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
    .busy(busy), .done(done), .result(result), .overflow(overflow)
  );

  dotprod_stream #(.DATA_W(8), .LEN_W(8), .ACC_W(16)) dut_s (
    .clk(clk), .rst(rst), .start(start_s), .len(len_s), .signed_mode(signed_mode_s),
    .in_valid(in_valid_s), .in_ready(in_ready_s), .in_a(in_a_s), .in_b(in_b_s),
    .busy(busy_s), .done(done_s), .result(result_s), .overflow(overflow_s)
  );

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference: exact integer arithmetic; each add is range-checked against the
  // representable interval and wrapped by one span when it leaves it.
  function automatic void ref_dot(input logic [31:0] a[$], input logic [31:0] b[$],
                                  input bit sgn, input int dw, input int aw,
                                  output logic [127:0] res, output bit ovf);
    logic signed [127:0] span, lo, hi, acc, av, bv, x, dmask;
    span  = 128'sd1 <<< aw;
    dmask = (128'sd1 <<< dw) - 128'sd1;
    lo    = sgn ? -(span >>> 1) : 128'sd0;
    hi    = sgn ? (span >>> 1) - 128'sd1 : span - 128'sd1;
    acc   = 0;
    ovf   = 0;
    for (int i = 0; i < a.size(); i++) begin
      av = '0; av[31:0] = a[i]; av = av & dmask;
      bv = '0; bv[31:0] = b[i]; bv = bv & dmask;
      if (sgn && av[dw-1]) av = av - (128'sd1 <<< dw);
      if (sgn && bv[dw-1]) bv = bv - (128'sd1 <<< dw);
      x = acc + av * bv;
      if (x < lo || x > hi) begin
        ovf = 1;
        x = (x > hi) ? x - span : x + span;
      end
      acc = x;
    end
    res = acc & (span - 128'sd1);
  endfunction

  // Monitors: pop one expectation per done pulse; track in_ready outside busy.
  always @(negedge clk) begin
    exp_t e;
    if (in_ready && !busy) rdy_viol++;
    if (in_ready_s && !busy_s) rdy_viol++;
    if (done) begin
      if (q32.size() == 0) check("done32_unexpected", 1, 0);
      else begin
        e = q32.pop_front();
        check("result32", result, e.res);
        check("overflow32", overflow, e.ovf);
      end
    end
    if (done_s) begin
      if (q8.size() == 0) check("done8_unexpected", 1, 0);
      else begin
        e = q8.pop_front();
        check("result8", result_s, e.res);
        check("overflow8", overflow_s, e.ovf);
      end
    end
  end

  // gap: 0 back-to-back, 1 alternate bubbles, 2 random bubbles.
  task automatic run32(input int n, input bit sgn, input int gap, input bit poke,
                       input logic [127:0] er, input bit eo);
    int  i, guard;
    bit  acc_now;
    q32.push_back('{er, eo});
    start = 1; len = 8'(n); signed_mode = sgn;
    @(posedge clk); #1;
    start = 0;
    check("busy_after_start", busy, 1);
    i = 0; guard = 0;
    while (i < n && guard < 2000) begin
      case (gap)
        0:       in_valid = 1;
        1:       in_valid = (guard % 2 == 0);
        default: in_valid = ($urandom_range(0, 2) != 0);
      endcase
      in_a = qa[i]; in_b = qb[i];
      if (poke && guard == 2) begin start = 1; len = 8'd5; end
      else start = 0;
      acc_now = in_valid && in_ready;
      @(posedge clk); #1;
      if (acc_now) i++;
      guard++;
    end
    in_valid = 0; start = 0;
    if (i < n) check("accept_timeout", 1, 0);
    check("ready_low_after_last", in_ready, 0);
    if (n > 0) begin
      check("done_low_T", done, 0);
      @(posedge clk); #1;
      check("done_low_T1", done, 0);
    end
    @(posedge clk); #1;
    check("done_latency", done, 1);
    check("busy_low_at_done", busy, 0);
  endtask

  task automatic run8(input int n, input bit sgn, input logic [127:0] er, input bit eo);
    int i, guard;
    q8.push_back('{er, eo});
    start_s = 1; len_s = 8'(n); signed_mode_s = sgn;
    @(posedge clk); #1;
    start_s = 0;
    i = 0; guard = 0;
    while (i < n && guard < 500) begin
      in_valid_s = 1; in_a_s = qa[i][7:0]; in_b_s = qb[i][7:0];
      @(posedge clk); #1;
      if (in_ready_s || guard > 0) i++;
      guard++;
    end
    in_valid_s = 0;
    repeat (2) @(posedge clk);
    #1;
    check("done8_latency", done_s, 1);
  endtask

  task automatic load8(input logic [31:0] a [8], input logic [31:0] b [8]);
    qa.delete(); qb.delete();
    for (int k = 0; k < 8; k++) begin qa.push_back(a[k]); qb.push_back(b[k]); end
  endtask

  task automatic load_rand(input int n, input int dw);
    qa.delete(); qb.delete();
    for (int k = 0; k < n; k++) begin
      qa.push_back(dw == 32 ? $urandom() : $urandom_range(0, 255));
      qb.push_back(dw == 32 ? $urandom() : $urandom_range(0, 255));
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [127:0] er;
    bit           eo;
    int           n;
    logic [31:0]  a1 [8] = '{2, 7, 5, 3, 5, 6, 7, 8};
    logic [31:0]  b1 [8] = '{8, 7, 6, 5, 4, 3, 2, 1};
    logic [31:0]  a2 [8] = '{1, 2, 3, 4, 5, 6, 7, 8};
    logic [31:0]  b2 [8] = '{8, 7, 6, 5, 4, 3, 2, 1};
    logic [31:0]  b3 [8] = '{0, 1, 0, 1, 0, 1, 0, 1};

    rst = 1; start = 0; len = 0; signed_mode = 0; in_valid = 0; in_a = 0; in_b = 0;
    start_s = 0; len_s = 0; signed_mode_s = 0; in_valid_s = 0; in_a_s = 0; in_b_s = 0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_ready", in_ready, 0);
    check("rst_result", result, 0);
    check("rst_overflow", overflow, 0);
    rst = 0;
    @(posedge clk); #1;

    // directed: back-to-back, alternating bubbles, second vector set
    load8(a1, b1); run32(8, 0, 0, 0, 128'd170, 0);
    load8(a2, b2); run32(8, 0, 1, 0, 128'd120, 0);
    load8(a2, b3); run32(8, 0, 1, 0, 128'd20, 0);

    // signed vs unsigned interpretation of the same operands
    qa = '{32'hFFFF_FFFD, 32'd4}; qb = '{32'd5, 32'hFFFF_FFFE};
    run32(2, 1, 0, 0, (128'd1 << 72) - 128'd23, 0);
    qa = '{32'hFFFF_FFFD, 32'd4}; qb = '{32'd5, 32'hFFFF_FFFE};
    run32(2, 0, 0, 0, (128'd9 << 32) - 128'd23, 0);

    // empty operation, then a start pulse while busy that must be ignored
    qa.delete(); qb.delete();
    run32(0, 0, 0, 0, 128'd0, 0);
    qa = '{32'd3, 32'd4, 32'd5}; qb = '{32'd10, 32'd100, 32'd1000};
    run32(3, 0, 0, 1, 128'd5430, 0);
    repeat (5) @(posedge clk);
    #1;
    check("result_held", result, 128'd5430);

    // narrow instance: unsigned wrap and signed overflow
    qa = '{32'd255, 32'd255}; qb = '{32'd255, 32'd255};
    run8(2, 0, 128'd64514, 1);
    qa = '{32'h80, 32'h80}; qb = '{32'h80, 32'h80};
    ref_dot(qa, qb, 1, 8, 16, er, eo);
    run8(2, 1, er, eo);
    for (int t = 0; t < 6; t++) begin
      n = $urandom_range(1, 6);
      load_rand(n, 8);
      ref_dot(qa, qb, t[0], 8, 16, er, eo);
      run8(n, t[0], er, eo);
    end

    // randomized wide operations, including the maximum length
    for (int t = 0; t < 7; t++) begin
      n = (t == 6) ? 255 : $urandom_range(1, 16);
      load_rand(n, 32);
      ref_dot(qa, qb, t[0], 32, 72, er, eo);
      run32(n, t[0], 2, 0, er, eo);
    end

    // asynchronous reset in the middle of an operation
    load8(a2, b2);
    start = 1; len = 8; signed_mode = 0;
    @(posedge clk); #1;
    start = 0;
    for (int k = 0; k < 3; k++) begin
      in_valid = 1; in_a = qa[k]; in_b = qb[k];
      @(posedge clk); #1;
    end
    #3 rst = 1;
    #1;
    check("midrst_busy", busy, 0);
    check("midrst_ready", in_ready, 0);
    check("midrst_done", done, 0);
    check("midrst_result", result, 0);
    check("midrst_overflow", overflow, 0);
    check("midrst_result8", result_s, 0);
    in_valid = 0;
    #2 rst = 0;
    @(posedge clk); #1;
    load_rand(8, 32);
    ref_dot(qa, qb, 0, 32, 72, er, eo);
    run32(8, 0, 0, 0, er, eo);

    repeat (4) @(posedge clk);
    #1;
    check("pending_expect32", q32.size(), 0);
    check("pending_expect8", q8.size(), 0);
    check("ready_outside_run", rdy_viol, 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
